// File: rtl/tone_square_gen_pkg.sv
// Shared types and defaults for the square-wave tone generator.
//   state_e    : FSM state encoding (IDLE / PLAY / RELEASE)
//   PW_DEFAULT : default half-period counter width
//   is_off     : classifies a command as a note-off
package tone_square_gen_pkg;

  localparam int unsigned PW_DEFAULT          = 16;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // A zero half-period is treated the same as an explicit note-off.
  function automatic logic is_off(input logic on, input logic period_zero);
    return !on || period_zero;
  endfunction

endpackage

// File: rtl/tone_square_gen_edge_sync.sv
// Synchroniser plus rising-edge detector for a slow divided clock.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input level
//   rise     : one-clk pulse after each synchronised rising edge of d
module tone_square_gen_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // Shift chain; the delay flop holds the previous synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/tone_square_gen.sv
// Square-wave tone generator driven by a divided reference clock.
//   clk, rst    : system clock, async active-high reset
//   tick_in     : divided reference clock (slow, asynchronous)
//   cmd_valid / cmd_ready : command handshake
//   cmd_on, cmd_period    : note on/retune (period>0) or note off
//   tone_out    : square wave output
//   busy        : generator not idle
//   tick_ce     : synchronised rising-edge enable of tick_in
module tone_square_gen
  import tone_square_gen_pkg::*;
#(
  parameter int unsigned PW          = PW_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_in,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_on,
  input  logic [PW-1:0] cmd_period,
  output logic          tone_out,
  output logic          busy,
  output logic          tick_ce
);

  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          tone_q, tone_d;
  logic          busy_q, busy_d;

  logic accept;
  logic cmd_off;
  logic toggle;

  tone_square_gen_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (tick_in),
    .rise (tick_ce)
  );

  // Commands are refused only while a high half-cycle is draining.
  assign cmd_ready = (state_q != ST_RELEASE);
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_off   = is_off(cmd_on, cmd_period == '0);
  assign toggle    = tick_ce & (state_q != ST_IDLE) & (cnt_q == per_q - PW'(1));

  // Next-state, counter and period bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    pend_d  = pend_q;
    tone_d  = tone_q;

    // Half-period counter; a retune lands in per_q only at a toggle.
    if (state_q != ST_IDLE) begin
      if (toggle) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
        per_d  = pend_q;
      end else if (tick_ce) begin
        cnt_d = cnt_q + PW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && !cmd_off) begin
          state_d = ST_PLAY;
          per_d   = cmd_period;
          pend_d  = cmd_period;
          cnt_d   = '0;
        end
      end
      ST_PLAY: begin
        if (accept) begin
          if (!cmd_off) begin
            pend_d = cmd_period;
          end else if (toggle) begin
            // Falling toggle ends the note now; rising one must drain.
            state_d = tone_q ? ST_IDLE : ST_RELEASE;
          end else if (tone_q) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      ST_RELEASE: begin
        if (toggle) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      pend_q  <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
    end
  end

  assign tone_out = tone_q;
  assign busy     = busy_q;

endmodule
